// File: rtl/alu_seq_md.sv
// alu_seq_md: multi-cycle ALU for the execute stage.
// RV32I base ops finish in one cycle. RV32M multiply runs as an iterative
// shift-add and divide as a restoring divide, one step per cycle.
// Optional feature macro: ALU_DIV_EN. When it is defined, the divider is built.
// When it is undefined, the divide op codes are reported as illegal.
module alu_seq_md #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cf,
    output logic         zf,
    output logic         vf,
    output logic         sf,
    output logic         out_illegal
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [4:0] OP_ADD   = 5'b0_0000;
    localparam logic [4:0] OP_SUB   = 5'b0_0001;
    localparam logic [4:0] OP_PASSB = 5'b0_0011;
    localparam logic [4:0] OP_OR    = 5'b0_0100;
    localparam logic [4:0] OP_AND   = 5'b0_0101;
    localparam logic [4:0] OP_XOR   = 5'b0_0111;
    localparam logic [4:0] OP_SRL   = 5'b0_1000;
    localparam logic [4:0] OP_SLL   = 5'b0_1001;
    localparam logic [4:0] OP_SRA   = 5'b0_1010;
    localparam logic [4:0] OP_SLT   = 5'b0_1101;
    localparam logic [4:0] OP_SLTU  = 5'b0_1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc, acc_nx;
    logic [N-1:0]   md;
    logic [1:0]     op_r;
    logic           neg_q;

    logic           accept, last, busy;
    logic           is_mul, is_div, base_legal, illegal;
    logic           a_sgn, b_sgn, sa, sb;
    logic [N-1:0]   a_mag, b_mag;

    logic           sub_op;
    logic [N-1:0]   bop;
    logic [N:0]     sum;
    logic           base_vf;
    logic [N-1:0]   base_res;
    logic signed [N-1:0] a_s;
    logic [SHW-1:0] shamt;

    logic [N:0]     mul_sum;
    logic [2*N-1:0] prod;
    logic [N-1:0]   mul_res, m_res;

`ifdef ALU_DIV_EN
    logic           neg_r, dz;
    logic [N:0]     div_sh, div_diff;
    logic [N-1:0]   q_f, r_f, div_res;
`endif

    // Conditional two's-complement negation, N bits wide.
    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic en);
        return en ? (~v + N'(1)) : v;
    endfunction

    // Conditional two's-complement negation, 2N bits wide.
    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic en);
        return en ? (~v + (2*N)'(1)) : v;
    endfunction

    assign accept = in_valid & (state == IDLE) & ~flush;
    assign busy   = (state == MUL) | (state == DIV);
    assign last   = (cnt == CW'(1));

    assign is_mul = op[4] & ~op[3] & ~op[2];
`ifdef ALU_DIV_EN
    assign is_div = op[4] & ~op[3] & op[2];
`else
    assign is_div = 1'b0;
`endif
    assign illegal = ~(base_legal | is_mul | is_div);

    // Multiply: MUL/MULH sign both, MULHSU signs a only. Divide: DIV/REM sign both.
    assign a_sgn = is_mul ? (op[1:0] != 2'b11) : ~op[0];
    assign b_sgn = is_mul ? ~op[1] : ~op[0];
    assign sa    = a_sgn & a[N-1];
    assign sb    = b_sgn & b[N-1];
    assign a_mag = neg_n(a, sa);
    assign b_mag = neg_n(b, sb);

    assign sub_op  = (op == OP_SUB) | (op == OP_SLT) | (op == OP_SLTU);
    assign bop     = sub_op ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, bop} + {{N{1'b0}}, sub_op};
    assign base_vf = a[N-1] ^ bop[N-1] ^ sum[N-1] ^ sum[N];
    assign a_s     = a;
    assign shamt   = b[SHW-1:0];

    // Single-cycle base op result and legality decode.
    always_comb begin
        base_res   = '0;
        base_legal = 1'b1;
        case (op)
            OP_ADD, OP_SUB: base_res = sum[N-1:0];
            OP_PASSB:       base_res = b;
            OP_OR:          base_res = a | b;
            OP_AND:         base_res = a & b;
            OP_XOR:         base_res = a ^ b;
            OP_SRL:         base_res = a >> shamt;
            OP_SLL:         base_res = a << shamt;
            OP_SRA:         base_res = a_s >>> shamt;
            OP_SLT:         base_res = {{(N-1){1'b0}}, sum[N-1] ^ base_vf};
            OP_SLTU:        base_res = {{(N-1){1'b0}}, ~sum[N]};
            default:        base_legal = 1'b0;
        endcase
    end

    assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, md} : {(N+1){1'b0}});
`ifdef ALU_DIV_EN
    assign div_sh   = {acc[2*N-1:N], acc[N-1]};
    assign div_diff = div_sh - {1'b0, md};
`endif

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        acc_nx = acc;
        if (state == MUL) begin
            acc_nx = {mul_sum, acc[N-1:1]};
        end
`ifdef ALU_DIV_EN
        else if (state == DIV) begin
            acc_nx = div_diff[N] ? {div_sh[N-1:0], acc[N-2:0], 1'b0}
                                 : {div_diff[N-1:0], acc[N-2:0], 1'b1};
        end
`endif
    end

    // Final sign fix-up is applied to the value produced by the last step.
    assign prod    = neg_2n(acc_nx, neg_q);
    assign mul_res = (op_r == 2'b00) ? prod[N-1:0] : prod[2*N-1:N];
`ifdef ALU_DIV_EN
    // Divide by zero keeps the all-ones quotient regardless of the dividend sign.
    assign q_f     = dz ? {N{1'b1}} : neg_n(acc_nx[N-1:0], neg_q);
    assign r_f     = neg_n(acc_nx[2*N-1:N], neg_r);
    assign div_res = op_r[1] ? r_f : q_f;
    assign m_res   = (state == DIV) ? div_res : mul_res;
`else
    assign m_res   = mul_res;
`endif

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                cnt <= CW'(N);
            else if (busy)
                cnt <= cnt - CW'(1);
        end
    end

    // Next-state and handshake outputs; flush always returns to IDLE.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_nx = is_mul ? MUL : (is_div ? DIV : DONE);
            end
            MUL, DIV: begin
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    // Operand capture, iteration datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            cf          <= 1'b0;
            zf          <= 1'b0;
            vf          <= 1'b0;
            sf          <= 1'b0;
            out_illegal <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                out_illegal <= illegal;
                if (is_mul || is_div) begin
                    acc   <= is_mul ? {{N{1'b0}}, b_mag} : {{N{1'b0}}, a_mag};
                    md    <= is_mul ? a_mag : b_mag;
                    neg_q <= sa ^ sb;
                    op_r  <= op[1:0];
`ifdef ALU_DIV_EN
                    neg_r <= sa;
                    dz    <= (b == '0);
`endif
                end else if (illegal) begin
                    result <= '0;
                    cf     <= 1'b0;
                    zf     <= 1'b0;
                    vf     <= 1'b0;
                    sf     <= 1'b0;
                end else begin
                    result <= base_res;
                    cf     <= sum[N];
                    vf     <= base_vf;
                    zf     <= (base_res == '0);
                    sf     <= base_res[N-1];
                end
            end else if (busy) begin
                acc <= acc_nx;
                if (last) begin
                    result <= m_res;
                    cf     <= 1'b0;
                    vf     <= 1'b0;
                    zf     <= (m_res == '0);
                    sf     <= m_res[N-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_md.sv
// tb_alu_seq_md: scoreboard bench for alu_seq_md (N=32).
// Expected results come from a behavioural model built on the language's
// own *, / and % operators and are queued at issue time.
module tb_alu_seq_md;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    logic        cf, zf, vf, sf, out_illegal;

    alu_seq_md #(.N(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cf(cf), .zf(zf), .vf(vf), .sf(sf), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        ill;
        logic [3:0]  flg;   // {cf, zf, vf, sf}
        bit          fchk;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic vld_prev = 1'b0;

    localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, PASSB = 5'h03, OR_ = 5'h04, AND_ = 5'h05;
    localparam logic [4:0] XOR_ = 5'h07, SRL = 5'h08, SLL = 5'h09, SRA = 5'h0A, SLT = 5'h0D;
    localparam logic [4:0] SLTU = 5'h0F, MULL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
    localparam logic [4:0] DIVS = 5'h14, DIVU = 5'h15, REMS = 5'h16, REMU = 5'h17;
    localparam logic [4:0] CODES [21] = '{ADD, SUB, PASSB, OR_, AND_, XOR_, SRL, SLL, SRA, SLT,
                                          SLTU, MULL, MULH, MULHSU, MULHU, DIVS, DIVU, REMS,
                                          REMU, 5'h06, 5'h18};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [32:0] s;
        logic signed [31:0] xs, ys;
        logic signed [63:0] xl, yl, yu, ps;
        logic [63:0] pu;
        bit m;
        e.res = '0; e.ill = 1'b0; e.flg = '0; e.fchk = 0; e.lat = 1; e.acc = 0; e.op = o;
        xs = x; ys = y; xl = xs; yl = ys; yu = {32'h0, y};
        m = 0;
        case (o)
            ADD: begin
                s = {1'b0, x} + {1'b0, y};
                e.res = s[31:0]; e.fchk = 1;
                e.flg = {s[32], s[31:0] == 32'h0, (x[31] == y[31]) && (s[31] != x[31]), s[31]};
            end
            SUB, SLT, SLTU: begin
                s[31:0] = x - y;
                e.res = (o == SUB) ? s[31:0] : (o == SLT) ? {31'h0, xs < ys} : {31'h0, x < y};
                e.fchk = 1;
                e.flg = {x >= y, e.res == 32'h0, (x[31] != y[31]) && (s[31] != x[31]), e.res[31]};
            end
            PASSB: e.res = y;
            OR_:   e.res = x | y;
            AND_:  e.res = x & y;
            XOR_:  e.res = x ^ y;
            SRL:   e.res = x >> y[4:0];
            SLL:   e.res = x << y[4:0];
            SRA:   e.res = xs >>> y[4:0];
            MULL:   begin ps = xl * yl; e.res = ps[31:0];  m = 1; end
            MULH:   begin ps = xl * yl; e.res = ps[63:32]; m = 1; end
            MULHSU: begin ps = xl * yu; e.res = ps[63:32]; m = 1; end
            MULHU:  begin pu = {32'h0, x} * {32'h0, y}; e.res = pu[63:32]; m = 1; end
`ifdef ALU_DIV_EN
            DIVS: begin
                m = 1;
                if (y == 0) e.res = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = x;
                else e.res = xs / ys;
            end
            REMS: begin
                m = 1;
                if (y == 0) e.res = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = 32'h0;
                else e.res = xs % ys;
            end
            DIVU: begin m = 1; e.res = (y == 0) ? 32'hFFFF_FFFF : x / y; end
            REMU: begin m = 1; e.res = (y == 0) ? x : x % y; end
`endif
            default: e.ill = 1'b1;
        endcase
        if (m) begin
            e.lat = 33; e.fchk = 1;
            e.flg = {1'b0, e.res == 32'h0, 1'b0, e.res[31]};
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Result-side scoreboard: latency on the rising out_valid, data on handshake.
    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 1'b0;
        end else begin
            if (out_valid && !vld_prev) begin
                if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'h0);
                else chk($sformatf("latency op%02h", sb[0].op), cyc - sb[0].acc + 1, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                me = sb.pop_front();
                chk($sformatf("result op%02h", me.op), result, me.res);
                chk($sformatf("illegal op%02h", me.op), 32'(out_illegal), 32'(me.ill));
                if (me.fchk) chk($sformatf("flags op%02h", me.op), 32'({cf, zf, vf, sf}), 32'(me.flg));
            end
            vld_prev = out_valid;
        end
    end

    // Drive one op, wait for in_ready, queue the expectation if tracked.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
        int guard;
        exp_t e;
        guard = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'h1);
        end else if (track) begin
            e = model(o, x, y);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bit saw;
        int guard;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", 32'({cf, zf, vf, sf}), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_illegal", 32'(out_illegal), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // Directed cases
        issue(ADD, 32'h7FFF_FFFF, 32'h1, 1);
        issue(SUB, 32'd5, 32'd5, 1);
        issue(MULH, 32'hFFFF_FFFE, 32'd3, 1);
        issue(MULL, 32'hFFFF_FFFE, 32'd3, 1);
        issue(DIVS, 32'hFFFF_FFF9, 32'd2, 1);
        issue(REMS, 32'hFFFF_FFF9, 32'd2, 1);
        issue(DIVU, 32'd7, 32'd0, 1);
        issue(REMS, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(DIVS, 32'hFFFF_FFF9, 32'd0, 1);
        issue(REMU, 32'd100, 32'd7, 1);
        issue(5'h06, 32'h1234, 32'h5678, 1);
        issue(SRA, 32'h8000_0010, 32'h24, 1);
        issue(SRL, 32'h8000_0010, 32'h4, 1);
        issue(SLL, 32'h0000_0003, 32'h1F, 1);
        issue(SLT, 32'hFFFF_FFFF, 32'h1, 1);
        issue(SLTU, 32'hFFFF_FFFF, 32'h1, 1);
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(PASSB, 32'h0, 32'hCAFE_BABE, 1);

        // Random mix
        for (int i = 0; i < 40; i++)
            issue(CODES[$urandom_range(0, 20)], pick(), pick(), 1);
        drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(XOR_, 32'hA5A5_0F0F, 32'h0FF0_1234, 1);
        held = 32'hA5A5_0F0F ^ 32'h0FF0_1234;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) begin
            chk("bp_result_stable", result, held);
            chk("bp_in_ready_low", 32'(in_ready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        issue(OR_, 32'h0F00_0000, 32'h0000_00F0, 1);
        drain();

        // Flush together with in_valid accepts nothing
        op = ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_noaccept_in_ready", 32'(in_ready), 32'h1);
        chk("flush_noaccept_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // Flush 5 cycles into a long op
`ifdef ALU_DIV_EN
        issue(DIVU, 32'd1000, 32'd7, 0);
`else
        issue(MULHU, 32'd1000, 32'd7, 0);
`endif
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        chk("flush_no_out_valid", 32'(saw), 32'h0);
        @(posedge clk); #1;
        issue(ADD, 32'd2, 32'd3, 1);
        drain();

        // Reset 5 cycles into a multiply
        issue(MULHU, 32'hFFFF_0000, 32'h1234_5678, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_result", result, 32'h0);
        chk("midrst_flags", 32'({cf, zf, vf, sf}), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        chk("midrst_no_out_valid", 32'(saw), 32'h0);
        @(posedge clk); #1;
        issue(ADD, 32'd2, 32'd3, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
